// File: rtl/fifo_256x8_reader_if.sv
// Byte stream from the FIFO read adapter to the register/APB side.
// The master drives valid/data and the slave drives ready.
interface fifo_256x8_reader_if #(
   parameter int unsigned WIDTH = 8
);
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/fifo_256x8_reader.sv
// Read-side adapter for the UART 256x8 FIFO: issues pops, tracks the fixed read latency and
// lands returned bytes in a small skid buffer that feeds a valid/ready byte stream.
module fifo_256x8_reader #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       flush,
   input  logic                       fifo_empty,
   output logic                       fifo_re,
   input  logic [WIDTH-1:0]           fifo_do,
   fifo_256x8_reader_if.master        m_if,
   output logic [1:0]                 m_level,
   output logic                       busy
);

   localparam int unsigned DEPTH = RD_LATENCY + 1;

   logic [RD_LATENCY-1:0] track_q, track_d;
   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [1:0]            head_q, head_d;
   logic [1:0]            tail_q, tail_d;
   logic [2:0]            occ_q, occ_d;
   logic [2:0]            inflight;
   logic [3:0]            credit;
   logic                  push;
   logic                  pop;
   logic                  valid;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
         inflight = inflight + 3'(track_q[i]);
      end
   end

   assign push  = track_q[RD_LATENCY-1];
   assign valid = (occ_q != 3'd0);
   assign pop   = valid && m_if.m_ready;

   // Every issued read owns a buffer slot until it is consumed, so a return is never dropped.
   assign credit  = {1'b0, occ_q} + {1'b0, inflight} - {3'b000, pop};
   assign fifo_re = RESET_N && !fifo_empty && !flush && (credit < 4'(DEPTH));

   always_comb begin
      track_d = '0;
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         track_d[0] = fifo_re;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            track_d[i] = track_q[i-1];
         end
         if (push) begin
            tail_d = ptr_inc(tail_q);
         end
         if (pop) begin
            head_d = ptr_inc(head_q);
         end
         unique case ({push, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         track_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         track_q <= track_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         if (push && !flush) begin
            mem_q[tail_q] <= fifo_do;
         end
      end
   end

   assign m_if.m_valid = valid;
   assign m_if.m_data  = mem_q[head_q];
   // A four-entry buffer cannot be shown in two bits; report it as saturated.
   assign m_level      = (occ_q > 3'd3) ? 2'd3 : occ_q[1:0];
   assign busy         = valid || (track_q != '0);

   // The issue rule reserves a slot per read, so a landing byte always finds room.
   assert property (@(posedge CLK) disable iff (!RESET_N)
                    (push && !flush) |-> (occ_q < 3'(DEPTH)));

endmodule

// File: tb/tb_fifo_256x8_reader.sv
// Directed and randomized bench for fifo_256x8_reader with a timed-scoreboard reference model
// and a behavioural FIFO read port (registered empty flag, fixed read latency).
module tb_fifo_256x8_reader;
   localparam int unsigned RD_LATENCY = 2;
   localparam int          DEPTH      = RD_LATENCY + 1;

   typedef struct {
      logic [7:0] d;
      int         t;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       fifo_empty;
   logic       fifo_re;
   logic [7:0] fifo_do;
   logic [1:0] m_level;
   logic       busy;

   fifo_256x8_reader_if #(.WIDTH(8)) s_if ();

   fifo_256x8_reader #(
      .WIDTH      (8),
      .RD_LATENCY (RD_LATENCY)
   ) dut (
      .CLK        (clk),
      .RESET_N    (rst_n),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .fifo_do    (fifo_do),
      .m_if       (s_if),
      .m_level    (m_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0] fifo_q [$];
   ent_t       exp_q  [$];
   logic [7:0] got_q  [$];
   logic [7:0] want_q [$];
   logic [7:0] pipe   [RD_LATENCY];

   int re_cnt, first_re, last_re, first_val, beat_first, beat_last, c0;

   assign fifo_do = pipe[RD_LATENCY-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag);
      chk({tag, "_len"}, 32'(got_q.size()), 32'(want_q.size()));
      foreach (want_q[i]) begin
         if (i < got_q.size()) chk(tag, 32'(got_q[i]), 32'(want_q[i]));
      end
   endtask

   task automatic clr_stats();
      re_cnt     = 0;
      first_re   = -1;
      last_re    = -1;
      first_val  = -1;
      beat_first = -1;
      beat_last  = -1;
      got_q.delete();
      want_q.delete();
   endtask

   // One clock: sample and check mid-cycle, then advance the FIFO and scoreboard after the edge.
   task automatic cycle();
      logic s_re, s_flush, exp_valid, exp_pop, exp_re;
      int   lvl;
      #4;
      lvl = 0;
      foreach (exp_q[i]) if (exp_q[i].t <= cyc) lvl++;
      exp_valid = rst_n && (lvl != 0);
      exp_pop   = exp_valid && s_if.m_ready;
      exp_re    = rst_n && !fifo_empty && !flush && ((exp_q.size() - int'(exp_pop)) < DEPTH);
      chk("fifo_re", 32'(fifo_re), 32'(exp_re));
      chk("m_valid", 32'(s_if.m_valid), 32'(exp_valid));
      chk("m_level", 32'(m_level), 32'(rst_n ? lvl : 0));
      chk("busy", 32'(busy), 32'(rst_n && exp_q.size() != 0));
      if (exp_valid) chk("m_data", 32'(s_if.m_data), 32'(exp_q[0].d));
      s_re    = fifo_re;
      s_flush = flush;
      if (s_re) begin
         re_cnt++;
         if (first_re < 0) first_re = cyc;
         last_re = cyc;
      end
      if (s_if.m_valid && first_val < 0) first_val = cyc;
      if (s_if.m_valid && s_if.m_ready) begin
         got_q.push_back(s_if.m_data);
         if (beat_first < 0) beat_first = cyc;
         beat_last = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = int'(RD_LATENCY) - 1; i > 0; i--) pipe[i] = pipe[i-1];
      if (s_re && fifo_q.size() != 0) pipe[0] = fifo_q.pop_front();
      else pipe[0] = 8'($urandom);
      fifo_empty = (fifo_q.size() == 0);
      if (!rst_n || s_flush) begin
         exp_q.delete();
      end else begin
         if (exp_pop) void'(exp_q.pop_front());
         if (s_re) exp_q.push_back('{d: pipe[0], t: cyc + int'(RD_LATENCY) + 1});
      end
      cyc++;
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || !fifo_empty || exp_q.size() != 0) && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("idle_timeout", 32'(n < max_cyc), 32'(1));
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      fifo_empty  = 1'b1;
      s_if.m_ready = 1'b1;
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe[i] = 8'h00;
      clr_stats();
      @(posedge clk);
      #1;

      // Reset held with a non-empty FIFO: nothing is issued or presented.
      fifo_q.push_back(8'h10);
      fifo_q.push_back(8'h20);
      fifo_empty = 1'b0;
      repeat (3) cycle();
      chk("rst_m_data", 32'(s_if.m_data), 32'(0));
      chk("rst_re_cnt", 32'(re_cnt), 32'(0));
      rst_n = 1'b1;
      clr_stats();
      c0 = cyc;
      cycle();
      chk("rst_first_re", 32'(first_re), 32'(c0));
      run_until_idle(30);
      want_q.push_back(8'h10);
      want_q.push_back(8'h20);
      chk_seq("rst_data");

      // Streaming five bytes with the consumer always ready.
      clr_stats();
      for (int i = 1; i <= 5; i++) begin
         fifo_q.push_back(8'(8'h11 * i));
         want_q.push_back(8'(8'h11 * i));
      end
      run_until_idle(30);
      chk("stream_re_cnt", 32'(re_cnt), 32'(5));
      chk("stream_re_span", 32'(last_re - first_re), 32'(4));
      chk("stream_latency", 32'(first_val - first_re), 32'(3));
      chk("stream_beat_span", 32'(beat_last - beat_first), 32'(4));
      chk_seq("stream_data");
      chk("stream_busy", 32'(busy), 32'(0));

      // Back-pressure: only DEPTH reads go out, the head byte is held.
      clr_stats();
      s_if.m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         fifo_q.push_back(8'(8'hC0 + i));
         want_q.push_back(8'(8'hC0 + i));
      end
      repeat (10) cycle();
      chk("bp_re_cnt", 32'(re_cnt), 32'(3));
      chk("bp_level", 32'(m_level), 32'(3));
      chk("bp_hold_data", 32'(s_if.m_data), 32'(8'hC0));
      s_if.m_ready = 1'b1;
      run_until_idle(40);
      chk("bp_re_total", 32'(re_cnt), 32'(10));
      chk("bp_beat_span", 32'(beat_last - beat_first), 32'(9));
      chk_seq("bp_data");

      // Single byte followed by an empty FIFO.
      clr_stats();
      fifo_q.push_back(8'hA5);
      want_q.push_back(8'hA5);
      run_until_idle(20);
      repeat (3) cycle();
      chk("single_re_cnt", 32'(re_cnt), 32'(1));
      chk_seq("single_data");

      // Flush with one byte buffered and two reads in flight.
      clr_stats();
      s_if.m_ready = 1'b0;
      fifo_q.push_back(8'hB1);
      fifo_q.push_back(8'hB2);
      fifo_q.push_back(8'hB3);
      fifo_q.push_back(8'h7E);
      for (int n = 0; n < 12 && !s_if.m_valid; n++) cycle();
      chk("flush_pre_level", 32'(m_level), 32'(1));
      chk("flush_pre_re_cnt", 32'(re_cnt), 32'(3));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_valid_next", 32'(s_if.m_valid), 32'(0));
      clr_stats();
      s_if.m_ready = 1'b1;
      want_q.push_back(8'h7E);
      run_until_idle(20);
      repeat (3) cycle();
      chk_seq("flush_data");

      // Asynchronous reset in the middle of a stream.
      clr_stats();
      for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h30 + i));
      repeat (6) cycle();
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_re", 32'(fifo_re), 32'(0));
      chk("mrst_valid", 32'(s_if.m_valid), 32'(0));
      chk("mrst_level", 32'(m_level), 32'(0));
      chk("mrst_busy", 32'(busy), 32'(0));
      chk("mrst_data", 32'(s_if.m_data), 32'(0));
      fifo_q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      repeat (2) cycle();
      rst_n = 1'b1;
      clr_stats();
      fifo_q.push_back(8'h01);
      fifo_q.push_back(8'h02);
      want_q.push_back(8'h01);
      want_q.push_back(8'h02);
      run_until_idle(20);
      chk_seq("mrst_data_after");

      // Random traffic, stalls and occasional flushes against the scoreboard.
      clr_stats();
      repeat (1500) begin
         s_if.m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
         flush = ($urandom_range(0, 63) == 0);
         cycle();
      end
      flush = 1'b0;
      s_if.m_ready = 1'b1;
      run_until_idle(60);
      chk("rand_busy_end", 32'(busy), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_256x8_reader.md
# fifo_256x8_reader

Read-side stream adapter for the UART 256x8 FIFO. It issues pops to the FIFO, tracks reads whose data returns a fixed number of cycles later, and captures the returned bytes in a small skid buffer. The result is a back-pressured valid/ready byte stream for the register/APB side. It sits between the FIFO read port and the consumer, and sustains one byte per clock when the consumer is always ready.

## Interface
- `WIDTH`, default 8: data width.
- `RD_LATENCY`, default 2, legal 1..3: cycles from `fifo_re` high to data valid on `fifo_do`. The default covers the macro read plus the output register.
- `DEPTH`: derived, not overridable, equals `RD_LATENCY+1`. Skid buffer entries.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous discard of buffered and in-flight data.
- `fifo_empty` in 1: FIFO empty flag. Registered in the FIFO, and updated at the same edge that takes a pop.
- `fifo_re` out 1: pop request, active-high, one pop per cycle high.
- `fifo_do` in `WIDTH`: FIFO read data.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: consumer accepts the byte.
- `m_data` out `WIDTH`: output byte.
- `m_level` out 2: bytes held in the skid buffer (0..`DEPTH`).
- `busy` out 1: high when the skid buffer or in-flight tracker is non-empty.

## Operation
- In-flight tracker:
  - `RD_LATENCY`-bit shift register.
  - Bit 0 is loaded with `fifo_re` each cycle.
  - When the MSB is high, the current `fifo_do` is written into the skid buffer at the tail.
- Skid buffer: `DEPTH`-entry circular buffer with head/tail pointers that wrap modulo `DEPTH`, and an occupancy counter `occ`.
  - `m_data` = entry at the head.
  - `m_valid` = (`occ` != 0).
- Pop: when `m_valid && m_ready`, the head advances and `occ` decrements.
- Issue rule: `fifo_re` = `!fifo_empty && !flush && (occ + inflight - pop) < DEPTH`.
  - `inflight` is the popcount of the tracker.
  - `pop` is the consumer handshake in the same cycle.
  - This guarantees no returned byte is ever dropped.
- Push and pop in the same cycle: `occ` is unchanged and both pointers advance.
- Push into a full buffer cannot occur by construction. Verification must assert this.
- Flush, while high:
  - `fifo_re` = 0.
  - Tracker, pointers and `occ` clear at the edge.
  - `m_valid` is 0 the following cycle.
  - Data from reads issued before the flush is ignored, because the tracker is cleared.
  - Flush has priority over push and pop.
- Order is strictly FIFO. Each byte is presented exactly once.
- `m_data` is held stable while `m_valid && !m_ready`.

## Timing
- Reset values: `fifo_re`=0, `m_valid`=0, `m_data`=0, `m_level`=0, `busy`=0, tracker, pointers and `occ` all 0.
- `fifo_re` is combinational from `fifo_empty`, `flush`, `m_ready` and internal state.
- Latency:
  - `fifo_re` high in cycle t means the byte is captured at the end of cycle t+`RD_LATENCY`.
  - `m_valid` is high from cycle t+`RD_LATENCY`+1.
  - Best case, with the FIFO non-empty and `m_ready`=1, is `RD_LATENCY`+1 cycles from `fifo_empty` falling to the first `m_valid`.
- Throughput: one byte per cycle while the FIFO is non-empty and `m_ready`=1.
- Back-pressure: with `m_ready`=0, at most `DEPTH` reads are issued, then `fifo_re` stays 0 until a pop.
- Reset mid-operation: immediate asynchronous clear. Data in flight is lost, and the FIFO itself is reset by the same system reset.
- `m_level` and `busy` are registered-state derived and valid in the same cycle as `m_valid`.

## Test plan
- Reset: hold `RESET_N`=0 with `fifo_empty`=0 → `fifo_re`, `m_valid`, `m_level`, `busy` stay 0. After release, `fifo_re` goes high in the first cycle.
- Streaming: preload 0x11,0x22,0x33,0x44,0x55, `m_ready`=1 →
  - `fifo_re` is high for exactly 5 consecutive cycles.
  - `m_valid` rises 3 cycles after the first `fifo_re`.
  - Five consecutive beats appear in order.
  - `busy` returns to 0.
- Back-pressure: preload 10 bytes, `m_ready`=0 → exactly 3 pops issued, `m_level`=3, `m_data`=first byte held stable. Raising `m_ready` then delivers all 10 in order with no gap after the first pop.
- Single byte: one byte 0xA5 then `fifo_empty`=1 → exactly one pop, one beat 0xA5, and no further `fifo_re`.
- Flush: with 2 reads in flight and 1 buffered, pulse `flush` for 1 cycle →
  - `m_valid` is 0 the next cycle.
  - The in-flight bytes are never presented.
  - The next FIFO byte, 0x7E, is the first beat after the flush.
- Mid-stream reset: assert `RESET_N` low during streaming → all outputs 0 immediately. After release with the FIFO refilled with 0x01,0x02, output is 0x01 then 0x02.
